// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic register pipeline.
// Default geometry, occupancy-counter width and a population count for checks.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH = 8;
  localparam int DFF_PIPE_DEPTH = 3;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int popcount(input logic [63:0] bits, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (bits[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid flag plus a data register.
// Build option DFF_PIPE_DATA_RST_EN adds an asynchronous reset to the data register.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // load is this stage's ready: empty, or the downstream chain is moving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
    end
  end

  // Data only changes when a real beat arrives, so a held beat stays stable.
`ifdef DFF_PIPE_DATA_RST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load && up_valid) begin
      data <= up_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (load && up_valid) begin
      data <= up_data;
    end
  end
`endif

endmodule

// File: rtl/dff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
// Build option DFF_PIPE_DATA_RST_EN resets the data registers to zero.
//
// Handshake: a beat moves across a boundary on a rising edge only when the
// sender's valid and the receiver's ready are both high in that cycle; valid
// never depends on ready, and ready may depend combinationally on out_ready_i.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH,
  parameter int DEPTH = DFF_PIPE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] dat    [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic             chain;
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ;

  // Ready ripples from the output back to the input; an empty stage breaks it.
  always_comb begin
    rdy   = '0;
    chain = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || chain;
      chain  = rdy[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_vld[k] = in_valid_i;
      assign up_dat[k] = in_data_i;
    end else begin : g_body
      assign up_vld[k] = vld[k-1];
      assign up_dat[k] = dat[k-1];
    end

    dff_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush_i),
      .load    (rdy[k]),
      .up_valid(up_vld[k]),
      .up_data (up_dat[k]),
      .valid   (vld[k]),
      .data    (dat[k])
    );
  end

  assign in_ready_o  = rdy[0] && !flush_i;
  assign out_valid_o = vld[DEPTH-1] && !flush_i;
  assign out_data_o  = dat[DEPTH-1];

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  // Beats enter only at stage 0 and leave only at the last stage, so a
  // running in/out balance equals the number of set valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (flush_i) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  assign occ_o = occ;

  occ_matches_vld : assert property (
    @(posedge clk) disable iff (reset) int'(occ) == popcount(64'(vld), DEPTH)
  );

endmodule

// File: doc/dff_pipe.md
# dff_pipe

- Parametrised, elastic register pipeline: WIDTH bits wide, DEPTH stages deep, with a valid/ready handshake on both sides.
- Successor to the team's single-bit D flip-flop:
  - adds width and depth generalisation;
  - adds per-stage valid tracking with bubble collapsing and backpressure;
  - adds a synchronous flush alongside the asynchronous reset.
- Sits between producer and consumer blocks as a retiming/buffering stage.

## Interface
Parameters:
- WIDTH, 8, data bits per beat (>=1)
- DEPTH, 3, number of register stages (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush_i  input  1  synchronous clear of all stage valids
- in_valid_i  input  1  producer has a beat on in_data_i
- in_data_i  input  WIDTH  producer data
- in_ready_o  output  1  pipeline accepts a beat this cycle
- out_valid_o  output  1  beat available on out_data_o
- out_data_o  output  WIDTH  data of the last stage
- out_ready_i  input  1  consumer accepts the beat this cycle
- occ_o  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage state: vld[k], dat[k] for k=0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Stage ready: rdy[DEPTH-1] = !vld[DEPTH-1] || out_ready_i; rdy[k] = !vld[k] || rdy[k+1].
- Handshakes:
  - in_ready_o = rdy[0] && !flush_i.
  - Input transfer when in_valid_i && in_ready_o.
  - Output transfer when out_valid_o && out_ready_i.
- Advance: when rdy[k] is high, stage k loads from stage k-1, or from the input for k=0. vld[k] takes the upstream valid and dat[k] the upstream data. A stage with rdy[k] low holds.
- Bubble collapsing: an empty stage always accepts, even while downstream is stalled. This fills the internal gaps.
- out_valid_o = vld[DEPTH-1] && !flush_i. out_data_o = dat[DEPTH-1].
- Flush:
  - flush_i high clears every vld on the next edge.
  - No input or output transfer occurs in a flush cycle (flush wins over simultaneous valid/ready).
- occ_o is a registered count of set vld bits. It is updated in the same edge as the vld bits and reads 0 after reset or flush.
- DEPTH=1 is a single registered half-buffer stage. It still supports full throughput, because of the ready chain through rdy[DEPTH-1].

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - all vld=0, out_valid_o=0, occ_o=0;
  - in_ready_o=1 once reset is low;
  - dat[] reset value per Configuration.
- Latency:
  - DEPTH cycles from input transfer to out_valid_o with an empty pipeline and out_ready_i held high;
  - DEPTH beats in flight at steady state;
  - throughput 1 beat/cycle.
- in_ready_o depends combinationally on out_ready_i (ready chain). Valid and data paths are fully registered.
- Full (occ_o=DEPTH) with out_ready_i=0: in_ready_o=0 and all data is held stable.
- Full with out_ready_i=1: simultaneous input and output transfer; occ_o unchanged.
- Reset mid-stream: all in-flight beats are discarded immediately. No out_valid_o pulse occurs after reset.
- Flush and reset both active: reset dominates. Result is identical anyway.

## Configuration
- DFF_PIPE_DATA_RST_EN defined:
  - dat[] registers are also asynchronously reset to 0;
  - out_data_o=0 after reset.
- Undefined:
  - dat[] registers have no reset (cheaper flops);
  - out_data_o is undefined until the first beat reaches the last stage;
  - vld/occ reset behaviour is unchanged.
  - Benches must check out_data_o only when out_valid_o is high.

## Structure
- Shared package dff_pipe_pkg:
  - default WIDTH/DEPTH constants;
  - occupancy-width function clog2 of DEPTH+1.
- Sub-module dff_pipe_stage: one vld/dat stage with upstream/downstream valid and ready. The top instantiates DEPTH of these in a generate loop and adds the occupancy counter and flush gating.

## Test plan
- Reset then single beat: in_data_i=8'hA5 for one cycle, out_ready_i=1 -> out_valid_o high exactly 3 cycles later with 8'hA5, then low; occ_o 1,1,1,0.
- Streaming: 10 consecutive beats 1..10, out_ready_i=1 -> outputs 1..10 on consecutive cycles starting 3 cycles after first input; in_ready_o stays 1.
- Backpressure: out_ready_i=0, send beats 1,2,3,4 -> first three accepted, occ_o=3, in_ready_o=0 on the 4th; raise out_ready_i -> 1,2,3,4 emerge in order, no loss or duplication.
- Bubble collapse: send beats with gaps (1,_,2,_,3) while out_ready_i=0 -> occ_o reaches 3 and in_ready_o drops only when full.
- Flush: pipeline full with 7,8,9, assert flush_i one cycle with in_valid_i=1 -> no transfer that cycle, occ_o=0 next cycle, none of 7,8,9 or the flushed input ever appears.
- Async reset mid-stream: assert reset between clock edges with occ_o=2 -> out_valid_o and occ_o drop to 0 immediately; out_data_o=0 only with DFF_PIPE_DATA_RST_EN.
